// File: rtl/debug_mem.sv
// rtl/debug_mem.sv - Debug memory window: program buffer, abstract data, hart handshake flags, ROM routing
// Hart side is a 64-bit single-cycle port; the DM side addresses 32-bit words (data first, then progbuf).

module debug_mem #(
    parameter int ProgBufSize = 8,
    parameter int DataCount   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  be_i,
    output logic [63:0] rdata_o,
    output logic        rom_req_o,
    input  logic [63:0] rom_rdata_i,
    input  logic        go_i,
    input  logic        resume_i,
    output logic        halted_o,
    output logic        cmdbusy_o,
    output logic        cmddone_o,
    output logic        cmderr_o,
    output logic        resumeack_o,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o
);

    localparam int NWords = DataCount + ProgBufSize;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_EXEC,
        S_RESUME
    } state_e;

    state_e      state_q, state_d;
    logic        go_q, go_d;
    logic        resume_q, resume_d;
    logic        halted_q, halted_d;
    logic        cmddone_q, cmddone_d;
    logic        cmderr_q, cmderr_d;
    logic        resumeack_q, resumeack_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rom_sel_q, rom_sel_d;
    logic [31:0] mem_q [NWords];
    logic [31:0] mem_d [NWords];
    logic [63:0] local_rdata;

    logic        hart_wr;
    logic        hart_rd;
    logic [9:0]  word_addr;
    logic        wr_halted;
    logic        wr_going;
    logic        wr_resuming;
    logic        wr_exception;
    logic        unused_addr_bits;

    assign hart_wr      = req_i & we_i;
    assign hart_rd      = req_i & ~we_i;
    assign word_addr    = addr_i[11:2];
    assign wr_halted    = hart_wr && (word_addr == 10'h040);
    assign wr_going     = hart_wr && (word_addr == 10'h041);
    assign wr_resuming  = hart_wr && (word_addr == 10'h042);
    assign wr_exception = hart_wr && (word_addr == 10'h043);
    assign unused_addr_bits = ^{addr_i[63:12], addr_i[1:0]};

    // Byte address of storage word w as seen by the hart
    function automatic logic [11:0] word_byte_addr(input int w);
        if (w < DataCount) begin
            return 12'h380 + 12'(4 * w);
        end
        return 12'h340 + 12'(4 * (w - DataCount));
    endfunction

    always_comb begin
        logic [11:0] wa;
        wa          = '0;
        local_rdata = '0;
        if (addr_i[11:3] == 9'h080) begin
            local_rdata = {62'b0, resume_q, go_q};
        end
        for (int w = 0; w < NWords; w++) begin
            wa       = word_byte_addr(w);
            mem_d[w] = mem_q[w];
            if (addr_i[11:3] == wa[11:3]) begin
                if (wa[2]) begin
                    local_rdata[63:32] = mem_q[w];
                    for (int b = 0; b < 4; b++) begin
                        if (hart_wr && be_i[4+b]) begin
                            mem_d[w][8*b +: 8] = wdata_i[32+8*b +: 8];
                        end
                    end
                end else begin
                    local_rdata[31:0] = mem_q[w];
                    for (int b = 0; b < 4; b++) begin
                        if (hart_wr && be_i[b]) begin
                            mem_d[w][8*b +: 8] = wdata_i[8*b +: 8];
                        end
                    end
                end
            end
            // DM write overrides a concurrent hart write to the same word
            if (dm_we_i && (dm_addr_i == 4'(w))) begin
                mem_d[w] = dm_wdata_i;
            end
        end
    end

    always_comb begin
        dm_rdata_o = '0;
        for (int w = 0; w < NWords; w++) begin
            if (dm_addr_i == 4'(w)) begin
                dm_rdata_o = mem_q[w];
            end
        end
    end

    // After a ROM read with no new request, capture the ROM data so rdata_o keeps holding it
    always_comb begin
        rdata_d   = rdata_q;
        rom_sel_d = 1'b0;
        if (hart_rd) begin
            rdata_d   = local_rdata;
            rom_sel_d = addr_i[11];
        end else if (rom_sel_q) begin
            rdata_d = rom_rdata_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        go_d        = go_q;
        resume_d    = resume_q;
        halted_d    = halted_q;
        cmddone_d   = 1'b0;
        cmderr_d    = 1'b0;
        resumeack_d = 1'b0;
        if (wr_halted) begin
            halted_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (go_i && halted_q) begin
                    state_d = S_GO;
                    go_d    = 1'b1;
                end else if (resume_i && halted_q) begin
                    state_d  = S_RESUME;
                    resume_d = 1'b1;
                end
            end
            S_GO: begin
                if (wr_going) begin
                    state_d = S_EXEC;
                    go_d    = 1'b0;
                end
            end
            S_EXEC: begin
                if (wr_halted) begin
                    state_d   = S_IDLE;
                    cmddone_d = 1'b1;
                end else if (wr_exception) begin
                    state_d  = S_IDLE;
                    cmderr_d = 1'b1;
                end
            end
            S_RESUME: begin
                if (wr_resuming) begin
                    state_d     = S_IDLE;
                    resume_d    = 1'b0;
                    halted_d    = 1'b0;
                    resumeack_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            go_q        <= 1'b0;
            resume_q    <= 1'b0;
            halted_q    <= 1'b0;
            cmddone_q   <= 1'b0;
            cmderr_q    <= 1'b0;
            resumeack_q <= 1'b0;
            rdata_q     <= '0;
            rom_sel_q   <= 1'b0;
            for (int w = 0; w < NWords; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            resume_q    <= resume_d;
            halted_q    <= halted_d;
            cmddone_q   <= cmddone_d;
            cmderr_q    <= cmderr_d;
            resumeack_q <= resumeack_d;
            rdata_q     <= rdata_d;
            rom_sel_q   <= rom_sel_d;
            for (int w = 0; w < NWords; w++) begin
                mem_q[w] <= mem_d[w];
            end
        end
    end

    assign rom_req_o   = req_i & addr_i[11];
    assign rdata_o     = rom_sel_q ? rom_rdata_i : rdata_q;
    assign halted_o    = halted_q;
    assign cmdbusy_o   = (state_q == S_GO) || (state_q == S_EXEC);
    assign cmddone_o   = cmddone_q;
    assign cmderr_o    = cmderr_q;
    assign resumeack_o = resumeack_q;

endmodule

// File: tb/tb_debug_mem.sv
// tb/tb_debug_mem.sv - Scoreboard bench for debug_mem against a flag/array reference model
// Stimulus pushes per-cycle status and read expectations; a negedge monitor pops and compares.

module tb_debug_mem;

    localparam int PB = 8;
    localparam int DC = 2;
    localparam int NW = PB + DC;

    logic        clk = 1'b0;
    logic        rst_ni, req_i, we_i, go_i, resume_i, dm_we_i;
    logic [63:0] addr_i, wdata_i, rom_rdata_i, rdata_o;
    logic [7:0]  be_i;
    logic [3:0]  dm_addr_i;
    logic [31:0] dm_wdata_i, dm_rdata_o;
    logic        rom_req_o, halted_o, cmdbusy_o, cmddone_o, cmderr_o, resumeack_o;

    always #5 clk = ~clk;

    debug_mem #(.ProgBufSize(PB), .DataCount(DC)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o), .rom_req_o(rom_req_o),
        .rom_rdata_i(rom_rdata_i), .go_i(go_i), .resume_i(resume_i), .halted_o(halted_o),
        .cmdbusy_o(cmdbusy_o), .cmddone_o(cmddone_o), .cmderr_o(cmderr_o),
        .resumeack_o(resumeack_o), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit        halted, busy, done, err, rack;
        bit [63:0] rdata;
    } rec_t;

    rec_t        sb[$];
    bit [63:0]   rdq[$];
    rec_t        mr;
    logic        rd_seen = 1'b0;

    // Reference model: words indexed like the DM port, plus handshake flags
    bit [31:0] m_mem [NW];
    bit        m_halted, m_go, m_resume, m_busy, m_done, m_err, m_rack, m_init;
    bit [63:0] m_rdata;
    bit [63:0] cur_rom;
    bit        prev_rom_rd;

    logic        n_rst, n_req, n_we, n_go, n_resume, n_dmwe;
    logic [63:0] n_addr, n_wdata, n_rom;
    logic [7:0]  n_be;
    logic [3:0]  n_dmaddr;
    logic [31:0] n_dmwdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int idx_of(input int a);
        if (a >= 'h380 && a < 'h380 + 4 * DC) return (a - 'h380) / 4;
        if (a >= 'h340 && a < 'h340 + 4 * PB) return DC + (a - 'h340) / 4;
        return -1;
    endfunction

    function automatic bit [63:0] model_read(input int a);
        bit [63:0] v;
        int        i0, i1;
        v = '0;
        if (a >= 'h800) return cur_rom;
        if ((a >> 3) == 'h80) return {62'b0, m_resume, m_go};
        i0 = idx_of(a & ~7);
        i1 = idx_of((a & ~7) + 4);
        if (i0 >= 0) v[31:0] = m_mem[i0];
        if (i1 >= 0) v[63:32] = m_mem[i1];
        return v;
    endfunction

    task automatic model_step();
        int        a, aw, idx;
        bit        wr, old_halted;
        bit [63:0] rv;
        a  = int'(n_addr[11:0]);
        aw = a & ~3;
        wr = n_req && n_we;
        m_done = 0; m_err = 0; m_rack = 0;
        if (!n_rst) begin
            for (int i = 0; i < NW; i++) m_mem[i] = '0;
            m_halted = 0; m_go = 0; m_resume = 0; m_busy = 0; m_rdata = '0; m_init = 1;
            return;
        end
        old_halted = m_halted;
        if (n_req && !n_we) begin
            rv = model_read(a);
            rdq.push_back(rv);
            m_rdata = rv;
        end
        if (wr) begin
            for (int h = 0; h < 2; h++) begin
                idx = idx_of((a & ~7) + 4 * h);
                if (idx >= 0)
                    for (int b = 0; b < 4; b++)
                        if (n_be[4*h+b]) m_mem[idx][8*b +: 8] = n_wdata[32*h+8*b +: 8];
            end
        end
        if (n_dmwe && n_dmaddr < NW) m_mem[n_dmaddr] = n_dmwdata;
        if (wr && aw == 'h100) m_halted = 1;
        if (!m_busy && !m_resume) begin
            if (n_go && old_halted) begin m_busy = 1; m_go = 1; end
            else if (n_resume && old_halted) m_resume = 1;
        end else if (m_busy && m_go) begin
            if (wr && aw == 'h104) m_go = 0;
        end else if (m_busy) begin
            if (wr && aw == 'h100) begin m_busy = 0; m_done = 1; end
            else if (wr && aw == 'h10C) begin m_busy = 0; m_err = 1; end
        end else begin
            if (wr && aw == 'h108) begin m_resume = 0; m_halted = 0; m_rack = 1; end
        end
    endtask

    task automatic clr();
        n_rst = 1; n_req = 0; n_we = 0; n_addr = '0; n_wdata = '0; n_be = '0;
        n_go = 0; n_resume = 0; n_dmwe = 0; n_dmaddr = '0; n_dmwdata = '0;
        n_rom = {$urandom, $urandom};
    endtask

    task automatic tick();
        bit   rom_rd;
        rec_t r;
        rom_rd = n_req && !n_we && n_addr[11];
        // ROM data may only change when it is not being returned this cycle
        if (rom_rd && !prev_rom_rd) cur_rom = n_rom;
        prev_rom_rd = rom_rd;
        rst_ni = n_rst; req_i = n_req; we_i = n_we; addr_i = n_addr; wdata_i = n_wdata;
        be_i = n_be; go_i = n_go; resume_i = n_resume; dm_we_i = n_dmwe;
        dm_addr_i = n_dmaddr; dm_wdata_i = n_dmwdata; rom_rdata_i = cur_rom;
        #1;
        chk("rom_req", {63'b0, rom_req_o}, {63'b0, n_req & n_addr[11]});
        if (m_init) chk("dm_rdata", {32'b0, dm_rdata_o}, {32'b0, (n_dmaddr < NW) ? m_mem[n_dmaddr] : 32'b0});
        model_step();
        r.halted = m_halted; r.busy = m_busy; r.done = m_done; r.err = m_err;
        r.rack = m_rack; r.rdata = m_rdata;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic hw(input int a, input logic [63:0] d, input logic [7:0] be);
        clr(); n_req = 1; n_we = 1; n_addr = 64'(a); n_wdata = d; n_be = be; tick();
    endtask

    task automatic hr(input int a);
        clr(); n_req = 1; n_addr = 64'(a); tick();
    endtask

    always @(posedge clk) rd_seen <= req_i & ~we_i & rst_ni;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mr = sb.pop_front();
            chk("halted", {63'b0, halted_o}, {63'b0, mr.halted});
            chk("cmdbusy", {63'b0, cmdbusy_o}, {63'b0, mr.busy});
            chk("cmddone", {63'b0, cmddone_o}, {63'b0, mr.done});
            chk("cmderr", {63'b0, cmderr_o}, {63'b0, mr.err});
            chk("resumeack", {63'b0, resumeack_o}, {63'b0, mr.rack});
            chk("rdata_hold", rdata_o, mr.rdata);
        end
        if (rd_seen) begin
            if (rdq.size() == 0) begin
                n_checks++;
                $display("FAIL rdata: response cycle with no expectation, got %h", rdata_o);
            end else begin
                chk("rdata", rdata_o, rdq.pop_front());
            end
        end
    end

    initial begin
        int k;
        m_init = 0; prev_rom_rd = 0; cur_rom = '0;
        clr(); n_rst = 0;
        repeat (3) tick();
        // Command: halt, go, going, halted
        hw('h100, 64'h0, 8'hFF);
        clr(); n_go = 1; tick();
        hr('h400);
        hw('h104, 64'h0, 8'hFF);
        hr('h400);
        hw('h100, 64'h0, 8'hFF);
        clr(); tick();
        // Command ending in an exception
        clr(); n_go = 1; tick();
        hw('h104, 64'h0, 8'hFF);
        hw('h10C, 64'h0, 8'hFF);
        hr('h10C);
        // Resume, then go is ignored while running
        clr(); n_resume = 1; tick();
        hr('h400);
        hw('h108, 64'h0, 8'hFF);
        clr(); n_go = 1; tick();
        clr(); tick();
        // Byte lanes into data word 0 and DM readback
        hw('h380, 64'hDEADBEEF_12345678, 8'h0F);
        clr(); n_dmaddr = 0; tick();
        clr(); n_dmaddr = 1; tick();
        hr('h380);
        // ROM routing
        clr(); n_req = 1; n_addr = 64'h808; n_rom = 64'h7B302573_10852823; tick();
        clr(); tick();
        // DM and hart hit the same progbuf word together
        clr(); n_req = 1; n_we = 1; n_addr = 64'h340; n_wdata = 64'h11111111_22222222; n_be = 8'hFF;
        n_dmwe = 1; n_dmaddr = 4'(DC); n_dmwdata = 32'hCAFEF00D; tick();
        clr(); n_dmaddr = 4'(DC); tick();
        clr(); n_dmaddr = 4'(DC + 1); tick();
        clr(); n_dmwe = 1; n_dmaddr = 4'd12; n_dmwdata = 32'h5A5A5A5A; tick();
        clr(); n_dmaddr = 4'd12; tick();
        // go and resume together, then reset in the middle of the command
        hw('h100, 64'h0, 8'hFF);
        clr(); n_go = 1; n_resume = 1; tick();
        hr('h400);
        hw('h104, 64'h0, 8'hFF);
        clr(); n_rst = 0; tick();
        hr('h400);
        clr(); tick();
        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            clr();
            n_rst = ($urandom_range(0, 149) != 0);
            n_req = ($urandom_range(0, 9) < 6);
            n_we  = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0, 1:    k = 'h340 + 4 * $urandom_range(0, PB - 1);
                2:       k = 'h380 + 4 * $urandom_range(0, DC - 1);
                3:       k = 'h400;
                4, 5, 6: k = 'h100 + 4 * $urandom_range(0, 3);
                7:       k = 'h800 + $urandom_range(0, 'h7FF);
                default: begin
                    case ($urandom_range(0, 4))
                        0:       k = $urandom_range(0, 'hFF);
                        1:       k = $urandom_range('h110, 'h33F);
                        2:       k = $urandom_range('h340 + 4 * PB, 'h37F);
                        3:       k = $urandom_range('h380 + 4 * DC, 'h3FF);
                        default: k = $urandom_range('h408, 'h7FF);
                    endcase
                end
            endcase
            n_addr    = {$urandom, $urandom};
            n_addr[11:0] = 12'(k);
            n_wdata   = {$urandom, $urandom};
            n_be      = 8'($urandom);
            n_go      = ($urandom_range(0, 7) == 0);
            n_resume  = ($urandom_range(0, 7) == 0);
            n_dmwe    = ($urandom_range(0, 6) == 0);
            n_dmaddr  = 4'($urandom);
            n_dmwdata = $urandom;
            tick();
        end
        clr(); tick();
        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        chk("rdq_drain", 64'(rdq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_mem.md
DEBUG_MEM -- requirements
Module: debug_mem

Interface
REQ-001 SHALL have parameter ProgBufSize, default 8, number of 32-bit program-buffer words.
REQ-002 SHALL have parameter DataCount, default 2, number of 32-bit abstract-data words.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_i  input  1  hart access request.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  64  byte address; only addr_i[11:0] decoded.
REQ-008 SHALL have port wdata_i  input  64  write data.
REQ-009 SHALL have port be_i  input  8  byte enables.
REQ-010 SHALL have port rdata_o  output  64  read data, one cycle after request.
REQ-011 SHALL have port rom_req_o  output  1  request forwarded to the debug ROM.
REQ-012 SHALL have port rom_rdata_i  input  64  debug ROM read data.
REQ-013 SHALL have ports go_i, resume_i  input  1 each  DM pulses: start abstract command, resume hart.
REQ-014 SHALL have ports halted_o, cmdbusy_o  output  1 each  hart halted; abstract command in progress.
REQ-015 SHALL have ports cmddone_o, cmderr_o, resumeack_o  output  1 each  single-cycle status pulses.
REQ-016 SHALL have DM data port dm_we_i (1), dm_addr_i (4), dm_wdata_i (32) inputs, dm_rdata_o (32) output; index 0..DataCount-1 = data, DataCount.. = progbuf.

Function
REQ-017 SHALL decode hart offsets: 0x100 HALTED, 0x104 GOING, 0x108 RESUMING, 0x10C EXCEPTION (write-only), 0x340+4k progbuf, 0x380+4k data (read/write, 32-bit words packed two per 64-bit beat), 0x400 flags (read-only), 0x800-0xFFF ROM.
REQ-018 SHALL assert rom_req_o = req_i & addr_i[11] combinationally; registered select SHALL route rom_rdata_i to rdata_o in the following cycle.
REQ-019 SHALL return reads of progbuf/data/flags one cycle after req_i; unmapped offsets and write-only offsets SHALL read 0; rdata_o SHALL hold last value when no request.
REQ-020 SHALL apply hart writes to progbuf/data per be_i byte lanes; writes to flags, ROM or unmapped offsets SHALL be ignored.
REQ-021 SHALL return flags byte at 0x400: bit0 = go, bit1 = resume, other bits 0 (single hart, id 0; written hart IDs ignored).
REQ-022 SHALL implement FSM IDLE, GO, EXEC, RESUME; cmdbusy_o = 1 in GO and EXEC.
REQ-023 IDLE: go_i with halted_o=1 -> GO, go flag set; else resume_i with halted_o=1 -> RESUME, resume flag set; go_i wins if both; requests with halted_o=0 ignored.
REQ-024 GO: hart write to GOING -> EXEC, go flag cleared next cycle.
REQ-025 EXEC: write to HALTED -> IDLE with cmddone_o pulse; write to EXCEPTION -> IDLE with cmderr_o pulse; both written same cycle impossible (single port).
REQ-026 RESUME: write to RESUMING -> IDLE, resume flag cleared, halted_o cleared, resumeack_o pulse.
REQ-027 Write to HALTED in any state SHALL set halted_o next cycle; write to EXCEPTION outside EXEC SHALL be ignored.
REQ-028 go_i/resume_i outside IDLE SHALL be ignored.
REQ-029 DM port: dm_rdata_o combinational from dm_addr_i; dm_we_i write takes effect next edge; simultaneous hart and DM write to same word: DM wins; out-of-range index ignored, reads 0.

Reset
REQ-030 On rst_ni=0 at clock edge: FSM IDLE, flags 0, halted_o 0, all pulses 0, rdata_o 0, ROM select 0, progbuf and data cleared to 0; reset mid-command abandons it with no cmddone_o/cmderr_o.

Verification
REQ-031 Write 0 to 0x100, then go_i -> flags read 0x01, cmdbusy_o=1; write 0x104 -> flags 0x00; write 0x100 -> cmddone_o one cycle, cmdbusy_o=0.
REQ-032 In EXEC write 0x10C -> cmderr_o one cycle, state IDLE, halted_o unchanged 1.
REQ-033 Halted, resume_i -> flags 0x02; write 0x108 -> resumeack_o pulse, halted_o=0; subsequent go_i -> no state change.
REQ-034 Write 0xDEADBEEF_12345678 be=0x0F to 0x380 -> dm_addr_i=0 reads 0x12345678, dm_addr_i=1 reads 0.
REQ-035 Read 0x808 with rom_rdata_i=0x7B302573_10852823 -> rom_req_o=1 same cycle, rdata_o equals that value next cycle.
REQ-036 go_i and resume_i same cycle while halted -> GO, flags 0x01; rst_ni=0 during EXEC -> flags 0, halted_o 0, no pulses.
